regfile_scoreboard: RTL and testbench

//  Parametrised register file for the next-generation CPU: 2 read ports, 1 write port, synchronous reset.

---
 rtl/regfile_scoreboard.sv | 113 +++++++++++
 tb/tb_regfile_scoreboard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file (2 read / 1 write, r0 hardwired to zero, write-to-read bypass)
// with a per-register busy scoreboard that raises stall on RAW hazards.
module regfile_scoreboard #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    input  logic              use_rr1,
    input  logic              use_rr2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] wr,
    input  logic [WIDTH-1:0]  wd,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              stall,
    output logic [ADDR_W:0]   pending
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [WIDTH-1:0]    regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [ADDR_W:0]     pending_reg;
    logic [ADDR_W:0]     pending_next;

    logic wr_hit1;
    logic wr_hit2;
    logic busy1_eff;
    logic busy2_eff;
    logic issue_ok;

    assign wr_hit1 = regwrite && (wr == rr1);
    assign wr_hit2 = regwrite && (wr == rr2);

    always_comb begin
        rd1 = regs_reg[rr1];
        if (rr1 == '0) begin
            rd1 = '0;
        end else if (wr_hit1) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = regs_reg[rr2];
        if (rr2 == '0) begin
            rd2 = '0;
        end else if (wr_hit2) begin
            rd2 = wd;
        end
    end

    // A write landing this cycle satisfies the dependency through the bypass.
    assign busy1_eff = busy_reg[rr1] && !wr_hit1;
    assign busy2_eff = busy_reg[rr2] && !wr_hit2;
    assign stall     = (use_rr1 && busy1_eff) || (use_rr2 && busy2_eff);
    assign issue_ok  = issue_en && !stall;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_track
                logic set_hit;
                logic clr_hit;
                assign set_hit = issue_ok && (issue_addr == ADDR_W'(gi));
                assign clr_hit = regwrite && (wr == ADDR_W'(gi));
                // A new producer supersedes the one retiring in the same cycle.
                always_comb begin
                    busy_next[gi] = busy_reg[gi];
                    if (set_hit) begin
                        busy_next[gi] = 1'b1;
                    end else if (clr_hit) begin
                        busy_next[gi] = 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        pending_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_next = pending_next + (ADDR_W + 1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_reg    <= '0;
            pending_reg <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            busy_reg    <= busy_next;
            pending_reg <= pending_next;
            if (regwrite && (wr != '0)) begin
                regs_reg[wr] <= wd;
            end
        end
    end

    assign pending = pending_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against a small
// array-based reference model of the register file and its scoreboard.
module tb_regfile_scoreboard;

    localparam int W = 16;
    localparam int A = 2;
    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [A-1:0] rr1, rr2, wr, issue_addr;
    logic         use_rr1, use_rr2, regwrite, issue_en;
    logic [W-1:0] wd, rd1, rd2;
    logic         stall;
    logic [A:0]   pending;

    int checks = 0;
    int errors = 0;

    int m_regs [N];
    bit m_busy [N];

    regfile_scoreboard #(.WIDTH(W), .ADDR_W(A)) dut (
        .clock(clock), .reset(reset),
        .rr1(rr1), .rr2(rr2), .use_rr1(use_rr1), .use_rr2(use_rr2),
        .rd1(rd1), .rd2(rd2),
        .regwrite(regwrite), .wr(wr), .wd(wd),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .stall(stall), .pending(pending)
    );

    always #5 clock = ~clock;

    function automatic int exp_rd(int a);
        if (a == 0) return 0;
        if (regwrite && int'(wr) == a) return int'(wd);
        return m_regs[a];
    endfunction

    function automatic bit operand_blocked(bit used, int a);
        return used && m_busy[a] && !(regwrite && int'(wr) == a);
    endfunction

    function automatic bit exp_stall();
        return operand_blocked(use_rr1, int'(rr1)) || operand_blocked(use_rr2, int'(rr2));
    endfunction

    function automatic int exp_pending();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; rr1 = '0; rr2 = '0; use_rr1 = 1'b0; use_rr2 = 1'b0;
        regwrite = 1'b0; wr = '0; wd = '0; issue_en = 1'b0; issue_addr = '0;
    endtask

    // Checks combinational outputs, advances one edge, updates the model, checks pending.
    task automatic step(string tag);
        bit s;
        #1;
        chk({tag, ".rd1"}, 32'(rd1), 32'(exp_rd(int'(rr1))));
        chk({tag, ".rd2"}, 32'(rd2), 32'(exp_rd(int'(rr2))));
        s = exp_stall();
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_regs[i] = 0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (regwrite && wr != 0) m_regs[wr] = int'(wd);
            for (int i = 1; i < N; i++) begin
                if (issue_en && !s && int'(issue_addr) == i) m_busy[i] = 1'b1;
                else if (regwrite && int'(wr) == i) m_busy[i] = 1'b0;
            end
        end
        @(negedge clock);
        chk({tag, ".pending"}, 32'(pending), 32'(exp_pending()));
        $display("%s rst=%0d rr1=%0d rr2=%0d we=%0d wr=%0d wd=%h iss=%0d@%0d -> rd1=%h rd2=%h stall=%0d pending=%0d",
                 tag, reset, rr1, rr2, regwrite, wr, wd, issue_en, issue_addr, rd1, rd2, stall, pending);
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            m_regs[i] = 0;
            m_busy[i] = 1'b0;
        end
        idle();

        // Reset clears a written register
        regwrite = 1'b1; wr = 2'd1; wd = 16'h1234; step("t1_write");
        rr1 = 2'd1; #1; chk("t1_before_reset", 32'(rd1), 32'h1234);
        reset = 1'b1; step("t1_reset_a");
        reset = 1'b1; step("t1_reset_b");
        rr1 = 2'd1; #1;
        chk("t1_rd1", 32'(rd1), 32'h0);
        chk("t1_pending", 32'(pending), 32'h0);
        chk("t1_stall", 32'(stall), 32'h0);

        // Write and discarded write to r0
        regwrite = 1'b1; wr = 2'd2; wd = 16'h00FF; step("t2_w2");
        regwrite = 1'b1; wr = 2'd0; wd = 16'hBEEF; step("t2_w0");
        rr1 = 2'd2; rr2 = 2'd0; #1;
        chk("t2_rd1", 32'(rd1), 32'h00FF);
        chk("t2_rd2", 32'(rd2), 32'h0000);

        // Bypass
        regwrite = 1'b1; wr = 2'd3; wd = 16'h0007; step("t3_w3");
        regwrite = 1'b1; wr = 2'd3; wd = 16'h0016; rr1 = 2'd3; #1;
        chk("t3_bypass", 32'(rd1), 32'h0016);
        step("t3_bypass_edge");
        rr1 = 2'd3; #1; chk("t3_stored", 32'(rd1), 32'h0016);

        // RAW stall
        issue_en = 1'b1; issue_addr = 2'd1; step("t4_issue1");
        chk("t4_pending1", 32'(pending), 32'd1);
        rr1 = 2'd1; use_rr1 = 1'b1; issue_en = 1'b1; issue_addr = 2'd2; #1;
        chk("t4_stall", 32'(stall), 32'd1);
        step("t4_stalled_issue");
        chk("t4_pending_held", 32'(pending), 32'd1);
        rr1 = 2'd1; use_rr1 = 1'b1; regwrite = 1'b1; wr = 2'd1; wd = 16'h000F; #1;
        chk("t4_stall_cleared", 32'(stall), 32'd0);
        chk("t4_rd1_bypass", 32'(rd1), 32'h000F);
        step("t4_writeback");
        chk("t4_pending0", 32'(pending), 32'd0);

        // Set/clear race on r2
        issue_en = 1'b1; issue_addr = 2'd2; step("t5_issue2");
        issue_en = 1'b1; issue_addr = 2'd2; regwrite = 1'b1; wr = 2'd2; wd = 16'hA5A5; step("t5_race");
        chk("t5_pending", 32'(pending), 32'd1);
        rr1 = 2'd2; use_rr1 = 1'b1; #1;
        chk("t5_busy_kept", 32'(stall), 32'd1);
        chk("t5_reg", 32'(rd1), 32'hA5A5);
        idle();

        // Mid-operation reset
        regwrite = 1'b1; wr = 2'd2; wd = 16'h0001; step("t6_clear2");
        regwrite = 1'b1; wr = 2'd1; wd = 16'h4444; step("t6_w1");
        issue_en = 1'b1; issue_addr = 2'd1; step("t6_issue1");
        issue_en = 1'b1; issue_addr = 2'd3; step("t6_issue3");
        chk("t6_pending2", 32'(pending), 32'd2);
        reset = 1'b1; regwrite = 1'b1; wr = 2'd1; wd = 16'h9999; step("t6_reset");
        chk("t6_pending0", 32'(pending), 32'd0);
        rr1 = 2'd1; use_rr1 = 1'b1; rr2 = 2'd3; use_rr2 = 1'b1; #1;
        chk("t6_reg1", 32'(rd1), 32'h0);
        chk("t6_stall", 32'(stall), 32'd0);
        idle();

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            reset      = ($urandom_range(0, 59) == 0);
            rr1        = A'($urandom);
            rr2        = A'($urandom);
            use_rr1    = $urandom_range(0, 1) == 1;
            use_rr2    = $urandom_range(0, 1) == 1;
            regwrite   = $urandom_range(0, 2) == 0;
            wr         = A'($urandom);
            wd         = W'($urandom);
            issue_en   = $urandom_range(0, 2) == 0;
            issue_addr = A'($urandom);
            step($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
